// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit owning the architectural HI/LO
// registers.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, op         launch an op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU); start
//                     is sampled in IDLE only
//   op1, op2          multiplicand/dividend and multiplier/divisor
//   cancel            abort an in-flight op; HI/LO are left untouched
//   mthi, mtlo, wdata direct writes of HI/LO, honoured in IDLE when start is low
//   busy              high while the FSM is not in IDLE
//   done              one-cycle pulse; HI/LO already hold the new result
//   div_by_zero       valid with done
//   hi, lo            HI/LO registers
//
// Optional feature: define MDU_FAST_MUL_EN to compute MULT/MULTU with a
// single-cycle combinational multiplier. DIV/DIVU stay iterative. When the
// macro is undefined, every op takes the 33-cycle iterative path.
module mdu_hilo #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic              cancel,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int W = DATA_W;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*W-1:0]    acc_q;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [W-1:0]      dvsr_q;     // multiplicand or divisor magnitude
    logic [W-1:0]      op1_raw_q;  // original dividend, returned in HI on divide by zero
    logic [W-1:0]      hi_q, lo_q;
    logic              is_div_q, neg_lo_q, neg_hi_q, dz_q, done_q, dbz_q;

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic n);
        return n ? (~v) + {{(W-1){1'b0}}, 1'b1} : v;
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v, input logic n);
        return n ? (~v) + {{(2*W-1){1'b0}}, 1'b1} : v;
    endfunction

    // Operand magnitudes: two's-complement absolute value for signed ops.
    logic         op1_neg, op2_neg;
    logic [W-1:0] mag1, mag2;
    assign op1_neg = ~op[0] & op1[W-1];
    assign op2_neg = ~op[0] & op2[W-1];
    assign mag1    = neg_w(op1, op1_neg);
    assign mag2    = neg_w(op2, op2_neg);

    // Multiply step: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    logic [W:0]     add_sum;
    logic [2*W-1:0] mul_step_d;
    assign add_sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, dvsr_q};
    assign mul_step_d = acc_q[0] ? {add_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};

    // Restoring divide step: shift the next dividend bit into the remainder,
    // keep the difference if it did not borrow and record a quotient bit.
    logic [W:0]     trial;
    logic [2*W-1:0] div_step_d;
    assign trial      = {acc_q[2*W-1:W], acc_q[W-1]} - {1'b0, dvsr_q};
    assign div_step_d = trial[W] ? {acc_q[2*W-2:0], 1'b0}
                                 : {trial[W-1:0], acc_q[W-2:0], 1'b1};

    // Sign correction applied in FIX.
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix;
    assign prod_fix = neg_2w(acc_q, neg_lo_q);
    assign quo_fix  = neg_w(acc_q[W-1:0], neg_lo_q);
    assign rem_fix  = neg_w(acc_q[2*W-1:W], neg_hi_q);

`ifdef MDU_FAST_MUL_EN
    logic [2*W-1:0] fast_prod_d;
    assign fast_prod_d = {{W{1'b0}}, mag1} * {{W{1'b0}}, mag2};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        is_div_q  <= op[1];
                        neg_lo_q  <= op1_neg ^ op2_neg;
                        neg_hi_q  <= op1_neg;
                        dz_q      <= op[1] & (op2 == '0);
                        op1_raw_q <= op1;
                        cnt_q     <= '0;
                        if (op[1]) begin
                            acc_q   <= {{W{1'b0}}, mag1};
                            dvsr_q  <= mag2;
                            state_q <= RUN;
                        end else begin
`ifdef MDU_FAST_MUL_EN
                            acc_q   <= fast_prod_d;
                            dvsr_q  <= mag1;
                            state_q <= FIX;
`else
                            acc_q   <= {{W{1'b0}}, mag2};
                            dvsr_q  <= mag1;
                            state_q <= RUN;
`endif
                        end
                    end else begin
                        if (mthi) hi_q <= wdata;
                        if (mtlo) lo_q <= wdata;
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q <= is_div_q ? div_step_d : mul_step_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(W - 1)) state_q <= FIX;
                    end
                end
                FIX: begin
                    if (!cancel) begin
                        if (!is_div_q) begin
                            {hi_q, lo_q} <= prod_fix;
                        end else if (dz_q) begin
                            hi_q <= op1_raw_q;
                            lo_q <= '1;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                        done_q <= 1'b1;
                        dbz_q  <= dz_q;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
